// File: rtl/uart_phy_pkg.sv
// Shared types and helpers for the UART 8N1 PHY.
package uart_phy_pkg;

  localparam int UART_DATA_BITS  = 8;
  localparam int UART_FRAME_BITS = 10;  // start + 8 data + stop

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_e;

  // Integer clocks per bit; any fractional remainder is dropped.
  function automatic int calc_clks_per_bit(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/axi_stream_if.sv
// Minimal AXI-Stream link: one beat per cycle when tvalid && tready.
interface axi_stream_if #(
  parameter int DATA_W = 8
);
  logic              tvalid;
  logic              tready;
  logic [DATA_W-1:0] tdata;
  logic              tlast;

  modport master (output tvalid, output tdata, output tlast, input tready);
  modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/axis_byte_fifo.sv
// Synchronous first-word-fall-through FIFO with an AXI-Stream read side.
// A push is accepted when not full, or when full with a pop in the same cycle.
// A push that finds no room is dropped and flagged one cycle later on overrun.
module axis_byte_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             full,
  output logic             overrun,
  axi_stream_if.master     m_axis
);

  localparam int AW = $clog2(DEPTH);

  if (DEPTH < 2 || (1 << AW) != DEPTH) begin : g_bad_depth
    $error("axis_byte_fifo: DEPTH must be a power of two >= 2");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic             empty, pop, wr_en;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop   = m_axis.tvalid && m_axis.tready;
  assign wr_en = push && (!full || pop);

  assign m_axis.tvalid = !empty;
  assign m_axis.tdata  = mem[rd_ptr[AW-1:0]];
  assign m_axis.tlast  = 1'b0;

  // Storage write; no reset needed since reads are gated by the pointers.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  // Pointer update and dropped-push flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      overrun <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      overrun <= push && full && !pop;
    end
  end

endmodule

// File: rtl/uart_axis_phy.sv
// UART 8N1 PHY: serial rx -> byte FIFO -> rx_axis, tx_axis -> serial tx.
module uart_axis_phy
  import uart_phy_pkg::*;
#(
  parameter int CLK_FREQ_HZ   = 50_000_000,
  parameter int BAUD_RATE     = 115_200,
  parameter int RX_FIFO_DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         uart_rx_i,
  output logic         uart_tx_o,
  axi_stream_if.master rx_axis,
  axi_stream_if.slave  tx_axis,
  output logic         rx_frame_err,
  output logic         rx_overrun
);

  localparam int          CLKS_PER_BIT = calc_clks_per_bit(CLK_FREQ_HZ, BAUD_RATE);
  localparam logic [15:0] BIT_LAST     = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_LAST    = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [2:0]  IDX_LAST     = 3'(UART_DATA_BITS - 1);

  if (CLKS_PER_BIT < 4 || UART_FRAME_BITS != UART_DATA_BITS + 2) begin : g_bad_baud
    $error("uart_axis_phy: CLKS_PER_BIT must be >= 4");
  end

  // ---------------- RX ----------------
  logic                      rx_meta, rx_sync;
  rx_state_e                 rx_state, rx_state_nxt;
  logic [15:0]               rx_cnt, rx_cnt_nxt;
  logic [2:0]                rx_idx, rx_idx_nxt;
  logic [UART_DATA_BITS-1:0] rx_shift, rx_shift_nxt;
  logic                      rx_push, rx_ferr_nxt;
  logic                      unused_fifo_full;

  // Two-flop synchronizer; idle-high reset avoids a false start bit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= uart_rx_i;
      rx_sync <= rx_meta;
    end
  end

  // RX state register, bit timing and framing-error pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_state     <= RX_IDLE;
      rx_cnt       <= '0;
      rx_idx       <= '0;
      rx_shift     <= '0;
      rx_frame_err <= 1'b0;
    end else begin
      rx_state     <= rx_state_nxt;
      rx_cnt       <= rx_cnt_nxt;
      rx_idx       <= rx_idx_nxt;
      rx_shift     <= rx_shift_nxt;
      rx_frame_err <= rx_ferr_nxt;
    end
  end

  // RX next state: mid-bit sampling, LSB first; stop sample returns to idle at once.
  always_comb begin
    rx_state_nxt = rx_state;
    rx_cnt_nxt   = rx_cnt + 16'd1;
    rx_idx_nxt   = rx_idx;
    rx_shift_nxt = rx_shift;
    rx_push      = 1'b0;
    rx_ferr_nxt  = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        rx_cnt_nxt = '0;
        if (!rx_sync) rx_state_nxt = RX_START;
      end
      RX_START: begin
        if (rx_cnt == HALF_LAST) begin
          rx_cnt_nxt   = '0;
          rx_idx_nxt   = '0;
          rx_state_nxt = rx_sync ? RX_IDLE : RX_DATA;  // high here = glitch
        end
      end
      RX_DATA: begin
        if (rx_cnt == BIT_LAST) begin
          rx_cnt_nxt   = '0;
          rx_shift_nxt = {rx_sync, rx_shift[UART_DATA_BITS-1:1]};
          rx_idx_nxt   = rx_idx + 3'd1;
          if (rx_idx == IDX_LAST) rx_state_nxt = RX_STOP;
        end
      end
      RX_STOP: begin
        if (rx_cnt == BIT_LAST) begin
          rx_cnt_nxt   = '0;
          rx_state_nxt = RX_IDLE;
          rx_push      = rx_sync;
          rx_ferr_nxt  = !rx_sync;
        end
      end
      default: rx_state_nxt = RX_IDLE;
    endcase
  end

  axis_byte_fifo #(
    .DEPTH (RX_FIFO_DEPTH),
    .WIDTH (UART_DATA_BITS)
  ) u_rx_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (rx_push),
    .push_data (rx_shift),
    .full      (unused_fifo_full),
    .overrun   (rx_overrun),
    .m_axis    (rx_axis)
  );

  // ---------------- TX ----------------
  tx_state_e                 tx_state, tx_state_nxt;
  logic [15:0]               tx_cnt, tx_cnt_nxt;
  logic [2:0]                tx_idx, tx_idx_nxt;
  logic [UART_DATA_BITS-1:0] tx_shift, tx_shift_nxt;
  logic                      tx_line_nxt;
  logic                      unused_tlast;

  // The link is an unframed byte stream, so incoming tlast carries no meaning.
  assign unused_tlast   = tx_axis.tlast;
  assign tx_axis.tready = (tx_state == TX_IDLE) && rst_n;

  // TX state register; the line itself is registered so it never glitches.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_state  <= TX_IDLE;
      tx_cnt    <= '0;
      tx_idx    <= '0;
      tx_shift  <= '0;
      uart_tx_o <= 1'b1;
    end else begin
      tx_state  <= tx_state_nxt;
      tx_cnt    <= tx_cnt_nxt;
      tx_idx    <= tx_idx_nxt;
      tx_shift  <= tx_shift_nxt;
      uart_tx_o <= tx_line_nxt;
    end
  end

  // TX next state: the line level for the coming bit is chosen on each bit boundary.
  always_comb begin
    tx_state_nxt = tx_state;
    tx_cnt_nxt   = tx_cnt + 16'd1;
    tx_idx_nxt   = tx_idx;
    tx_shift_nxt = tx_shift;
    tx_line_nxt  = uart_tx_o;
    case (tx_state)
      TX_IDLE: begin
        tx_cnt_nxt  = '0;
        tx_line_nxt = 1'b1;
        if (tx_axis.tvalid && tx_axis.tready) begin
          tx_shift_nxt = tx_axis.tdata;
          tx_idx_nxt   = '0;
          tx_state_nxt = TX_START;
          tx_line_nxt  = 1'b0;
        end
      end
      TX_START: begin
        if (tx_cnt == BIT_LAST) begin
          tx_cnt_nxt   = '0;
          tx_state_nxt = TX_DATA;
          tx_line_nxt  = tx_shift[0];
        end
      end
      TX_DATA: begin
        if (tx_cnt == BIT_LAST) begin
          tx_cnt_nxt   = '0;
          tx_idx_nxt   = tx_idx + 3'd1;
          tx_shift_nxt = {1'b1, tx_shift[UART_DATA_BITS-1:1]};
          if (tx_idx == IDX_LAST) begin
            tx_state_nxt = TX_STOP;
            tx_line_nxt  = 1'b1;
          end else begin
            tx_line_nxt  = tx_shift[1];
          end
        end
      end
      TX_STOP: begin
        if (tx_cnt == BIT_LAST) begin
          tx_cnt_nxt   = '0;
          tx_state_nxt = TX_IDLE;
          tx_line_nxt  = 1'b1;
        end
      end
      default: tx_state_nxt = TX_IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_axis_phy.sv
// Scoreboard bench for uart_axis_phy: expected RX bytes and TX frames are queued
// by the stimulus and consumed by independent line/stream monitors.
module tb_uart_axis_phy;

  localparam int CPB   = 10;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rx_drv = 1'b1;
  logic lb = 1'b0;
  logic uart_rx, uart_tx, rx_frame_err, rx_overrun;

  axi_stream_if #(.DATA_W(8)) rx_if ();
  axi_stream_if #(.DATA_W(8)) tx_if ();

  assign uart_rx = lb ? uart_tx : rx_drv;

  uart_axis_phy #(
    .CLK_FREQ_HZ   (1_000_000),
    .BAUD_RATE     (100_000),
    .RX_FIFO_DEPTH (DEPTH)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .uart_rx_i    (uart_rx),
    .uart_tx_o    (uart_tx),
    .rx_axis      (rx_if),
    .tx_axis      (tx_if),
    .rx_frame_err (rx_frame_err),
    .rx_overrun   (rx_overrun)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int fe_cnt = 0, ov_cnt = 0;
  int exp_fe = 0, exp_ov = 0;
  bit tx_mon_en = 1'b1;
  logic [7:0] rx_q[$];
  logic [7:0] tx_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic fail_now(input string name, input string why);
    n_chk++;
    $display("FAIL %s: %s", name, why);
  endtask

  // Count high cycles of the error pulses; each event must be exactly one cycle.
  always @(negedge clk) begin
    if (rx_frame_err === 1'b1) fe_cnt++;
    if (rx_overrun === 1'b1) ov_cnt++;
  end

  // RX stream monitor: every accepted beat must match the oldest expected byte.
  always @(negedge clk) begin
    if (rst_n && rx_if.tvalid === 1'b1 && rx_if.tready === 1'b1) begin
      if (rx_q.size() == 0) begin
        fail_now("rx_unexpected_beat", $sformatf("got 0x%0h, expected no beat", rx_if.tdata));
      end else begin
        check("rx_tdata", rx_if.tdata, rx_q.pop_front());
        check("rx_tlast", rx_if.tlast, 0);
      end
    end
  end

  // TX line monitor: on a start edge, every one of the 100 line cycles must match
  // the 10-bit frame {stop, data, start}, CPB cycles per bit.
  logic [9:0] tm_frame;
  int         tm_errs;
  bit         tm_abort;
  initial forever begin
    @(negedge clk);
    if (rst_n && tx_mon_en && uart_tx === 1'b0) begin
      if (tx_q.size() == 0) begin
        fail_now("tx_unexpected_frame", "start bit seen with nothing queued");
        repeat (10 * CPB) @(negedge clk);
      end else begin
        tm_frame = {1'b1, tx_q.pop_front(), 1'b0};
        tm_errs  = 0;
        tm_abort = 1'b0;
        for (int k = 0; k < 10 * CPB; k++) begin
          if (k > 0) @(negedge clk);
          if (!rst_n) begin
            tm_abort = 1'b1;
            break;
          end
          if (uart_tx !== tm_frame[k / CPB]) tm_errs++;
        end
        if (!tm_abort) check("tx_frame_level_errors", tm_errs, 0);
      end
    end
  end

  // Drive one serial frame; the expected outcome is decided from FIFO occupancy.
  task automatic send_rx(input logic [7:0] b, input bit stop);
    logic [9:0] bits;
    if (!stop) exp_fe++;
    else if (rx_if.tready !== 1'b1 && rx_q.size() >= DEPTH) exp_ov++;
    else rx_q.push_back(b);
    bits = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx_drv = bits[i];
      repeat (CPB) @(negedge clk);
    end
    rx_drv = 1'b1;
  endtask

  // Offer one byte on tx_axis; optionally wait out the frame and time tready low.
  task automatic send_tx(input logic [7:0] b, input bit wait_done);
    int n;
    if (tx_mon_en) tx_q.push_back(b);
    tx_if.tdata  = b;
    tx_if.tvalid = 1'b1;
    n = 0;
    while (tx_if.tready !== 1'b1 && n < 2000) begin
      n++;
      @(negedge clk);
    end
    if (n >= 2000) fail_now("tx_handshake_timeout", "tready never rose");
    @(posedge clk);
    #1 tx_if.tvalid = 1'b0;
    if (wait_done) begin
      n = 0;
      @(negedge clk);
      while (tx_if.tready !== 1'b1 && n < 2000) begin
        n++;
        @(negedge clk);
      end
      check("tx_tready_low_cycles", n, 10 * CPB);
    end
  endtask

  task automatic wait_rx_drain(input string name);
    int n = 0;
    while (rx_q.size() != 0 && n < 2000) begin
      n++;
      @(negedge clk);
    end
    check(name, rx_q.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] r;
    tx_if.tvalid = 1'b0;
    tx_if.tdata  = '0;
    tx_if.tlast  = 1'b0;
    rx_if.tready = 1'b0;

    // Reset state
    repeat (4) @(negedge clk);
    check("rst_uart_tx", uart_tx, 1);
    check("rst_rx_tvalid", rx_if.tvalid, 0);
    check("rst_rx_tlast", rx_if.tlast, 0);
    check("rst_tx_tready", tx_if.tready, 0);
    check("rst_frame_err", rx_frame_err, 0);
    check("rst_overrun", rx_overrun, 0);
    rst_n = 1'b1;
    rx_if.tready = 1'b1;
    repeat (3) @(negedge clk);

    // Single RX byte, then a few random ones
    send_rx(8'hA5, 1'b1);
    repeat (20) @(negedge clk);
    wait_rx_drain("rx_a5_drained");
    for (int i = 0; i < 5; i++) send_rx(8'($urandom_range(0, 255)), 1'b1);
    repeat (20) @(negedge clk);
    wait_rx_drain("rx_random_drained");
    check("no_frame_err_yet", fe_cnt, 0);
    check("no_overrun_yet", ov_cnt, 0);

    // TX: fixed pattern then random bytes
    send_tx(8'h3C, 1'b1);
    for (int i = 0; i < 3; i++) send_tx(8'($urandom_range(0, 255)), 1'b1);

    // Short low glitch: no byte, no error, receiver still usable afterwards
    rx_drv = 1'b0;
    repeat (3) @(negedge clk);
    rx_drv = 1'b1;
    repeat (30) @(negedge clk);
    check("glitch_no_beat", rx_if.tvalid, 0);
    check("glitch_no_frame_err", fe_cnt, 0);
    r = 8'($urandom_range(0, 255));
    send_rx(r, 1'b1);
    repeat (20) @(negedge clk);
    wait_rx_drain("rx_after_glitch_drained");

    // Bad stop bit
    send_rx(8'h55, 1'b0);
    repeat (20) @(negedge clk);
    check("frame_err_cycles", fe_cnt, exp_fe);
    check("frame_err_no_beat", rx_if.tvalid, 0);

    // Overrun with a stalled consumer
    rx_if.tready = 1'b0;
    for (int i = 1; i <= 5; i++) send_rx(8'(i), 1'b1);
    repeat (20) @(negedge clk);
    check("overrun_cycles", ov_cnt, exp_ov);
    check("stall_tvalid", rx_if.tvalid, 1);
    check("stall_tdata", rx_if.tdata, rx_q[0]);
    repeat (15) @(negedge clk);
    check("stall_tdata_stable", rx_if.tdata, rx_q[0]);
    rx_if.tready = 1'b1;
    repeat (2) @(negedge clk);
    wait_rx_drain("overrun_fifo_drained");
    check("overrun_total", ov_cnt, 1);

    // Reset during bit 3 of 0xFF
    tx_mon_en = 1'b0;
    send_tx(8'hFF, 1'b0);
    @(negedge clk);
    check("tx_ff_start_bit", uart_tx, 0);
    repeat (43) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midtx_reset_line_high", uart_tx, 1);
    check("midtx_reset_tready", tx_if.tready, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_tready", tx_if.tready, 1);
    check("post_reset_line_high", uart_tx, 1);
    tx_mon_en = 1'b1;
    send_tx(8'($urandom_range(0, 255)), 1'b1);

    // Loopback tx -> rx
    lb = 1'b1;
    repeat (2) @(negedge clk);
    r = 8'($urandom_range(0, 255));
    rx_q.push_back(r);
    send_tx(r, 1'b1);
    repeat (20) @(negedge clk);
    wait_rx_drain("loopback_drained");
    lb = 1'b0;

    repeat (20) @(negedge clk);
    check("final_frame_err_cycles", fe_cnt, exp_fe);
    check("final_overrun_cycles", ov_cnt, exp_ov);
    check("final_tx_queue_empty", tx_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
